vector_pair_loader: RTL and testbench

- Ping-pong staging buffer directly upstream of the FP32 dot-product stage (VectorMultiplication).
- Accepts element pairs (a_i, b_i) serially, one pair per cycle, over a valid/ready stream.
- Packs each VLEN-element frame into the flat buses A/B. Element i occupies bits [32*i +: 32].
- Presents completed frames to the consumer with a valid/ready handshake. Two banks allow loading frame n+1 while frame n is held.

---
 rtl/vector_pair_loader.sv | 88 ++++++++
 tb/tb_vector_pair_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_pair_loader.sv
// Ping-pong staging buffer: packs serial (a, b) element pairs into VLEN-wide frames
// and hands completed frames to the dot-product stage over a valid/ready handshake.
module vector_pair_loader #(
    parameter int unsigned VLEN = 5,
    parameter int unsigned DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_a,
    input  logic [DW-1:0]      in_b,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW*VLEN-1:0] A,
    output logic [DW*VLEN-1:0] B,
    output logic               frame_err,
    output logic [1:0]         occupancy
);

    localparam int unsigned IW = (VLEN > 1) ? $clog2(VLEN) : 1;

    logic [DW*VLEN-1:0] bank_a_q [2];
    logic [DW*VLEN-1:0] bank_b_q [2];
    logic [1:0]         full_q;
    logic               wr_bank_q;
    logic               rd_bank_q;
    logic [IW-1:0]      idx_q;
    logic               frame_err_q;

    logic accept;
    logic at_end;
    logic complete;
    logic bad_frame;
    logic pop;

    assign in_ready  = !full_q[wr_bank_q];
    assign accept    = in_valid && in_ready;
    assign at_end    = (idx_q == IW'(VLEN - 1));
    assign complete  = accept && at_end && in_last;
    // Early end or missing end: in_last disagrees with the slot position.
    assign bad_frame = accept && (at_end != in_last);

    assign out_valid = full_q[rd_bank_q];
    assign pop       = out_valid && out_ready;
    assign A         = bank_a_q[rd_bank_q];
    assign B         = bank_b_q[rd_bank_q];
    assign frame_err = frame_err_q;
    assign occupancy = {1'b0, full_q[0]} + {1'b0, full_q[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_a_q[0] <= '0;
            bank_a_q[1] <= '0;
            bank_b_q[0] <= '0;
            bank_b_q[1] <= '0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            idx_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= bad_frame;

            if (accept) begin
                bank_a_q[wr_bank_q][DW*int'(idx_q) +: DW] <= in_a;
                bank_b_q[wr_bank_q][DW*int'(idx_q) +: DW] <= in_b;
                if (complete || bad_frame) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
            end

            // A completing bank is empty and a popping bank is full, so they never collide.
            if (complete) begin
                full_q[wr_bank_q] <= 1'b1;
                wr_bank_q         <= !wr_bank_q;
            end
            if (pop) begin
                full_q[rd_bank_q] <= 1'b0;
                rd_bank_q         <= !rd_bank_q;
            end
        end
    end

endmodule

// File: tb/tb_vector_pair_loader.sv
// Randomized scoreboard bench for vector_pair_loader: a frame-level model predicts
// completed frames, framing errors and buffer occupancy; a monitor compares at negedge.
module tb_vector_pair_loader;

    localparam int unsigned VLEN = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned W    = DW * VLEN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          frame_err;
    logic [1:0]    occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    vector_pair_loader #(.VLEN(VLEN), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .frame_err (frame_err),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: frames waiting for the consumer, and the frame being assembled.
    logic [DW-1:0] cur_a[$];
    logic [DW-1:0] cur_b[$];
    logic [W-1:0]  exp_a[$];
    logic [W-1:0]  exp_b[$];
    int            pend  = 0;
    logic          m_err = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pend = 0;
                m_err = 1'b0;
                cur_a.delete();
                cur_b.delete();
                exp_a.delete();
                exp_b.delete();
            end else begin
                bit acc, popm, done, bad;
                acc  = in_valid && (pend < 2);
                popm = (pend > 0) && out_ready;
                done = 1'b0;
                bad  = 1'b0;
                if (acc) begin
                    cur_a.push_back(in_a);
                    cur_b.push_back(in_b);
                    if (cur_a.size() == VLEN && in_last) done = 1'b1;
                    else if (in_last || cur_a.size() == VLEN) bad = 1'b1;
                    if (done) begin
                        logic [W-1:0] va, vb;
                        for (int i = 0; i < VLEN; i++) begin
                            va[i*DW +: DW] = cur_a[i];
                            vb[i*DW +: DW] = cur_b[i];
                        end
                        exp_a.push_back(va);
                        exp_b.push_back(vb);
                    end
                    if (done || bad) begin
                        cur_a.delete();
                        cur_b.delete();
                    end
                end
                pend  = pend + int'(done) - int'(popm);
                m_err = bad;
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready", W'(in_ready), W'(pend < 2));
                chk("out_valid", W'(out_valid), W'(pend > 0));
                chk("occupancy", W'(occupancy), W'(pend));
                chk("frame_err", W'(frame_err), W'(m_err));
                if (out_valid) begin
                    if (exp_a.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got A=%h expected no frame", A);
                    end else begin
                        chk("frame_A", A, exp_a[0]);
                        chk("frame_B", B, exp_b[0]);
                        if (out_ready) begin
                            void'(exp_a.pop_front());
                            void'(exp_b.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic last, output int waited);
        logic rdy;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        waited   = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", waited);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic last_flag, input int max_gap,
                              output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            send_pair($urandom, $urandom, (i == len - 1) ? last_flag : 1'b0, w);
            stalls += w;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
            #0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, W'(out_valid), '0);
        chk({tag, "_A"}, A, '0);
        chk({tag, "_B"}, B, '0);
        chk({tag, "_occupancy"}, W'(occupancy), '0);
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    endtask

    logic [DW-1:0] da[VLEN] = '{32'h404CCCCD, 32'h3F28F5C3, 32'hBF000000, 32'hBF000000, 32'h4034B4B5};
    logic [DW-1:0] db[VLEN] = '{32'h40866666, 32'h3F028F5C, 32'hC0CCCCCC, 32'h40CCCCCC, 32'hBF70F0F1};
    logic [DW-1:0] one_to_five[VLEN] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                         32'h40800000, 32'h40A00000};

    initial begin
        int w, st, total;
        bit stim_done;

        #7;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single frame.
        out_ready = 1'b1;
        for (int i = 0; i < VLEN; i++) send_pair(da[i], db[i], i == VLEN - 1, w);
        chk("single_out_valid", W'(out_valid), W'(1));
        chk("single_A_lo", W'(A[31:0]), W'(32'h404CCCCD));
        chk("single_A_hi", W'(A[159:128]), W'(32'h4034B4B5));
        chk("single_B_1", W'(B[63:32]), W'(32'h3F028F5C));
        @(posedge clk);
        #1;
        chk("single_pop_occ", W'(occupancy), '0);

        // Backpressure: two frames fill both banks, third stalls until a pop.
        out_ready = 1'b0;
        send_frame(VLEN, 1'b1, 0, st);
        send_frame(VLEN, 1'b1, 0, st);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_occupancy", W'(occupancy), W'(2));
        chk("bp_in_ready", W'(in_ready), '0);
        fork
            begin
                send_frame(VLEN, 1'b1, 0, st);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("bp_stalled", W'(st > 0), W'(1));
        repeat (4) @(posedge clk);
        #1;

        // Continuous streaming: no stalls with out_ready held high.
        total = 0;
        for (int f = 0; f < 20; f++) begin
            send_frame(VLEN, 1'b1, 0, st);
            total += st;
        end
        chk("stream_no_stall", W'(total), '0);
        repeat (3) @(posedge clk);
        #1;

        // Early end, then a good frame of 1.0..5.0.
        send_frame(3, 1'b1, 0, st);
        for (int i = 0; i < VLEN; i++) send_pair(one_to_five[i], one_to_five[VLEN-1-i],
                                                 i == VLEN - 1, w);
        chk("after_early_A0", W'(A[31:0]), W'(32'h3F800000));
        chk("after_early_A4", W'(A[159:128]), W'(32'h40A00000));
        repeat (2) @(posedge clk);
        #1;

        // Missing end, then a good frame.
        send_frame(VLEN, 1'b0, 0, st);
        chk("missing_err", W'(frame_err), W'(1));
        send_frame(VLEN, 1'b1, 0, st);
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic with gaps, framing errors and random consumer stalls.
        stim_done = 0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int k;
                    k = $urandom_range(0, 9);
                    if (k == 0) send_frame($urandom_range(1, VLEN - 1), 1'b1, 2, st);
                    else if (k == 1) send_frame(VLEN, 1'b0, 2, st);
                    else send_frame(VLEN, 1'b1, 2, st);
                end
                stim_done = 1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (pend != 0 || exp_a.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain_queue", W'(exp_a.size()), '0);

        // Async reset mid-frame with one bank full.
        out_ready = 1'b0;
        send_frame(VLEN, 1'b1, 0, st);
        send_frame(3, 1'b0, 0, st);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_frame(VLEN, 1'b1, 0, st);
        chk("post_rst_valid", W'(out_valid), W'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_drain", W'(exp_a.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
